vga_frame_ram: RTL

VGA_FRAME_RAM -- requirements
Module: vga_frame_ram

---
 rtl/vga_mem_pkg.sv | 22 ++
 rtl/vga_mem_bank.sv | 39 +++
 rtl/vga_frame_ram.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/vga_mem_pkg.sv
// Shared constants and helpers for the VGA frame RAM: legal read latencies
// and the saturating out-of-range access counter.
package vga_mem_pkg;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;
  localparam int unsigned OOR_CNT_W  = 16;
  localparam int unsigned OOR_SUM_W  = OOR_CNT_W + 1;

  typedef logic [OOR_CNT_W-1:0] oor_cnt_t;

  // Clear wins over increments; sum saturates at all-ones.
  function automatic oor_cnt_t oor_cnt_next(input oor_cnt_t cnt, input logic [1:0] inc,
                                            input logic clr);
    logic [OOR_SUM_W-1:0] sum;
    sum = {1'b0, cnt} + OOR_SUM_W'(inc);
    if (clr) return '0;
    if (sum[OOR_SUM_W-1]) return '1;
    return sum[OOR_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/vga_mem_bank.sv
// Inferred dual-port word array: port A byte-enable write / read, port B read.
// Read-first behaviour on both ports; no reset on storage or read registers.
module vga_mem_bank #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 25000,
  parameter int unsigned ADDR_W    = 15
) (
  input  logic                clk,
  input  logic                a_we_i,
  input  logic                a_re_i,
  input  logic [DATA_W/8-1:0] a_be_i,
  input  logic [ADDR_W-1:0]   a_addr_i,
  input  logic [DATA_W-1:0]   a_wdata_i,
  output logic [DATA_W-1:0]   a_rdata_o,
  input  logic                b_re_i,
  input  logic [ADDR_W-1:0]   b_addr_i,
  output logic [DATA_W-1:0]   b_rdata_o
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  always_ff @(posedge clk) begin
    if (a_we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (a_be_i[b]) mem[a_addr_i][b*8 +: 8] <= a_wdata_i[b*8 +: 8];
      end
    end
    if (a_re_i) a_rdata_q <= mem[a_addr_i];
    if (b_re_i) b_rdata_q <= mem[b_addr_i];
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/vga_frame_ram.sv
// Dual-port frame buffer: host read/write port s1, scanout read port s2,
// fixed read latency, write-to-scanout collision bypass, out-of-range counter.
module vga_frame_ram
  import vga_mem_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 25000,
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned RD_LAT    = 1,
  parameter string       INIT_FILE = "vga_frame_ram.hex"
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_W-1:0]    s1_address,
  input  logic                 s1_chipselect,
  input  logic                 s1_read,
  input  logic                 s1_write,
  input  logic [DATA_W/8-1:0]  s1_byteenable,
  input  logic [DATA_W-1:0]    s1_writedata,
  output logic [DATA_W-1:0]    s1_readdata,
  output logic                 s1_readdatavalid,
  input  logic [ADDR_W-1:0]    s2_address,
  input  logic                 s2_read,
  output logic [DATA_W-1:0]    s2_readdata,
  output logic                 s2_readdatavalid,
  input  logic                 clken,
  output logic [OOR_CNT_W-1:0] oor_count,
  input  logic                 oor_clear
);

  localparam int unsigned NB = DATA_W / 8;

  if ((DATA_W % 8) != 0 || DATA_W == 0) begin : g_bad_data_w
    $error("vga_frame_ram: DATA_W must be a non-zero multiple of 8");
  end
  if ((64'd1 << ADDR_W) < 64'(DEPTH)) begin : g_bad_addr_w
    $error("vga_frame_ram: 2**ADDR_W must be >= DEPTH");
  end
  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("vga_frame_ram: RD_LAT must be 1 or 2");
  end

  logic              s1_wr, s1_rd, s2_rd, s1_in, s2_in, collide;
  logic [1:0]        oor_inc;
  logic [DATA_W-1:0] be_bits, bank_a, bank_b, s1_dat1, s2_dat1;

  logic              s1_vld_q, s1_vld_d, s1_ok_q, s1_ok_d;
  logic              s2_vld_q, s2_vld_d, s2_ok_q, s2_ok_d;
  logic [DATA_W-1:0] byp_mask_q, byp_mask_d, byp_wdata_q, byp_wdata_d;
  oor_cnt_t          oor_cnt_q, oor_cnt_d;

  assign s1_wr   = s1_chipselect & s1_write & clken;
  assign s1_rd   = s1_chipselect & s1_read & ~s1_write & clken;
  assign s2_rd   = s2_read & clken;
  assign s1_in   = 32'(s1_address) < DEPTH;
  assign s2_in   = 32'(s2_address) < DEPTH;
  assign collide = s2_rd & s1_wr & s1_in & s2_in & (s1_address == s2_address);
  assign oor_inc = 2'((s1_wr | s1_rd) & ~s1_in) + 2'(s2_rd & ~s2_in);

  always_comb begin
    be_bits = '0;
    for (int b = 0; b < NB; b++) be_bits[b*8 +: 8] = {8{s1_byteenable[b]}};
  end

  vga_mem_bank #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_bank (
    .clk       (clk),
    .a_we_i    (s1_wr & s1_in),
    .a_re_i    (s1_rd & s1_in),
    .a_be_i    (s1_byteenable),
    .a_addr_i  (s1_address),
    .a_wdata_i (s1_writedata),
    .a_rdata_o (bank_a),
    .b_re_i    (s2_rd & s2_in),
    .b_addr_i  (s2_address),
    .b_rdata_o (bank_b)
  );

  // Stage-1 state: valid flags, in-range flags and the collision overlay.
  always_comb begin
    s1_vld_d    = s1_vld_q;
    s1_ok_d     = s1_ok_q;
    s2_vld_d    = s2_vld_q;
    s2_ok_d     = s2_ok_q;
    byp_mask_d  = byp_mask_q;
    byp_wdata_d = byp_wdata_q;
    oor_cnt_d   = oor_cnt_next(oor_cnt_q, oor_inc, oor_clear);
    if (clken) begin
      s1_vld_d = s1_rd;
      s2_vld_d = s2_rd;
      if (s1_rd) s1_ok_d = s1_in;
      if (s2_rd) begin
        s2_ok_d     = s2_in;
        byp_mask_d  = collide ? be_bits : '0;
        byp_wdata_d = s1_writedata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld_q    <= 1'b0;
      s1_ok_q     <= 1'b0;
      s2_vld_q    <= 1'b0;
      s2_ok_q     <= 1'b0;
      byp_mask_q  <= '0;
      byp_wdata_q <= '0;
      oor_cnt_q   <= '0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_ok_q     <= s1_ok_d;
      s2_vld_q    <= s2_vld_d;
      s2_ok_q     <= s2_ok_d;
      byp_mask_q  <= byp_mask_d;
      byp_wdata_q <= byp_wdata_d;
      oor_cnt_q   <= oor_cnt_d;
    end
  end

  // Bank read registers only load on in-range reads, so these hold between reads.
  assign s1_dat1 = s1_ok_q ? bank_a : '0;
  assign s2_dat1 = s2_ok_q ? ((bank_b & ~byp_mask_q) | (byp_wdata_q & byp_mask_q)) : '0;
  assign oor_count = oor_cnt_q;

  if (RD_LAT == 1) begin : g_lat1
    assign s1_readdata      = s1_dat1;
    assign s1_readdatavalid = s1_vld_q;
    assign s2_readdata      = s2_dat1;
    assign s2_readdatavalid = s2_vld_q;
  end else begin : g_lat2
    logic              s1_vld2_q, s2_vld2_q;
    logic [DATA_W-1:0] s1_dat2_q, s2_dat2_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s1_vld2_q <= 1'b0;
        s2_vld2_q <= 1'b0;
        s1_dat2_q <= '0;
        s2_dat2_q <= '0;
      end else if (clken) begin
        s1_vld2_q <= s1_vld_q;
        s2_vld2_q <= s2_vld_q;
        if (s1_vld_q) s1_dat2_q <= s1_dat1;
        if (s2_vld_q) s2_dat2_q <= s2_dat1;
      end
    end

    assign s1_readdata      = s1_dat2_q;
    assign s1_readdatavalid = s1_vld2_q;
    assign s2_readdata      = s2_dat2_q;
    assign s2_readdatavalid = s2_vld2_q;
  end

endmodule
